mc_ctrl_fsm: RTL and testbench
==============================

Name: mc_ctrl_fsm

Overview:
- Multi-cycle CPU main control unit.
- Sequences the shared datapath: PC, IR, register file, ALU, single memory port, and the 2:1/4:1 operand and address muxes.
- Moore FSM: mux selects and write strobes decode from the state register; memory accesses stall on a ready handshake.
- Sits between the IR opcode field and the datapath control pins in the multi-cycle CPU top.

Parameters:
- STATE_W, 4, state register width; must hold all 12 states.
- OPC_W, 6, opcode field width (IR[31:26]).

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset; one clock, synchronous reset, no other clock domains.
- opcode  in  6  IR[31:26]; sampled only in state ID.
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory handshake; access completes in any cycle where the strobe and mem_ready are both 1.
- pc_write  out  1  unconditional PC load.
- pc_write_cond  out  1  PC load qualified by zero.
- pc_en  out  1  pc_write | (pc_write_cond & zero); combinational.
- iord  out  1  memory address mux: 0=PC, 1=ALUOut.
- mem_read  out  1  memory read strobe.
- mem_write  out  1  memory write strobe.
- ir_write  out  1  IR load.
- mem_to_reg  out  1  write-data mux: 0=ALUOut, 1=MDR.
- reg_dst  out  1  destination mux: 0=rt, 1=rd.
- reg_write  out  1  register file write enable.
- alu_src_a  out  1  ALU A mux: 0=PC, 1=A register.
- alu_src_b  out  2  ALU B mux: 00=B, 01=4, 10=sign-extended imm, 11=sign-extended imm<<2.
- alu_op  out  2  00=add, 01=sub, 10=funct, 11=immediate op (feature only).
- pc_source  out  2  PC mux: 00=ALU, 01=ALUOut, 10=jump target.
- illegal_op  out  1  one-cycle registered pulse on an undecoded opcode.
- state_o  out  4  current state, for debug and the bench.

Behaviour:
- States: IF=0, ID=1, MADDR=2, MRD=3, MWB=4, MWR=5, REX=6, RWB=7, BEQ=8, JMP=9, IEX=10, IWB=11.
- Reset: rst=1 at an edge forces state=IF and illegal_op=0, regardless of current state, including mid-memory access. Any pending access is abandoned; no write strobe is asserted after the reset edge.
- Every output not listed for a state is 0.
- IF: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00.
  - ir_write = mem_ready; pc_write = mem_ready.
  - Stay in IF while mem_ready=0; go to ID when mem_ready=1.
- ID: alu_src_a=0, alu_src_b=11, alu_op=00 (branch target into ALUOut). Next state by opcode:
  - 100011 or 101011 -> MADDR
  - 000000 -> REX
  - 000100 -> BEQ
  - 000010 -> JMP
  - feature opcodes -> IEX
  - anything else -> IF, with illegal_op=1 on the following cycle.
- MADDR: alu_src_a=1, alu_src_b=10, alu_op=00. Go to MRD if lw, MWR if sw; opcode is re-read, IR is stable.
- MRD: mem_read=1, iord=1. Hold until mem_ready, then MWB.
- MWB: reg_write=1, mem_to_reg=1, reg_dst=0. Then IF.
- MWR: mem_write=1, iord=1. Hold until mem_ready, then IF.
- REX: alu_src_a=1, alu_src_b=00, alu_op=10. Then RWB.
- RWB: reg_write=1, reg_dst=1, mem_to_reg=0. Then IF.
- BEQ: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01. Then IF.
- JMP: pc_write=1, pc_source=10. Then IF.
- Cycle counts with zero-wait memory: lw=5, sw=4, R-type=4, beq=3, j=3, illegal=2.
- Each wait cycle adds one cycle. mem_ready outside IF/MRD/MWR is ignored.
- Undefined state encodings (12-15) go to IF on the next edge.

Optional Feature:
- Macro: MC_IMM_ALU_EN.
- Defined: ID decodes 001000 (addi), 001100 (andi), 001101 (ori), 001010 (slti) -> IEX.
  - IEX: alu_src_a=1, alu_src_b=10, alu_op=11.
  - IWB: reg_write=1, reg_dst=0, mem_to_reg=0. Then IF.
  - The ALU control block derives the operation from the opcode when alu_op=11.
- Undefined: these opcodes are illegal (ID -> IF, illegal_op pulse). IEX/IWB encodings are unreachable and are treated as undefined states.

Decomposition:
- Shared package `mc_pkg`:
  - state encodings and opcode constants;
  - alu_op codes;
  - alu_src_b codes;
  - pc_source codes.
- One natural sub-module: `mc_ctrl_decode`, a purely combinational state -> output-vector decoder. The FSM top holds the state register, next-state logic and the illegal_op register.

Test Plan:
- Reset, then opcode=000000 with mem_ready=1 throughout -> states 0,1,6,7,0.
  - ir_write=1 in cycle 0; reg_write=1 and reg_dst=1 in cycle 3 only.
- lw, mem_ready low for 2 cycles in IF and 3 cycles in MRD -> total 10 cycles.
  - mem_read held high and iord=1 throughout MRD; mem_to_reg=1 in MWB.
- beq with zero=1, then with zero=0 -> pc_en=1 in the BEQ cycle only when zero=1; pc_source=01.
- opcode=111111 -> ID -> IF; illegal_op=1 for exactly one cycle; no reg_write or mem_write.
- sw stalled in MWR (mem_ready=0), rst=1 for one edge -> state_o=0 next cycle; mem_write=0 thereafter.
- With MC_IMM_ALU_EN, opcode=001101 -> states 0,1,10,11,0 with alu_op=11 in IEX. Without the macro -> illegal_op pulse.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle CPU main control unit.
// These cover the FSM states, opcodes, datapath mux codes and the control bundle.
package mc_pkg;

   localparam int STATE_BITS = 4;
   localparam int OPC_BITS   = 6;

   typedef enum logic [STATE_BITS-1:0] {
      S_IF    = 4'd0,
      S_ID    = 4'd1,
      S_MADDR = 4'd2,
      S_MRD   = 4'd3,
      S_MWB   = 4'd4,
      S_MWR   = 4'd5,
      S_REX   = 4'd6,
      S_RWB   = 4'd7,
      S_BEQ   = 4'd8,
      S_JMP   = 4'd9,
      S_IEX   = 4'd10,
      S_IWB   = 4'd11
   } state_e;

   typedef logic [OPC_BITS-1:0] opc_t;

   localparam opc_t OP_RTYPE = 6'b000000;
   localparam opc_t OP_J     = 6'b000010;
   localparam opc_t OP_BEQ   = 6'b000100;
   localparam opc_t OP_ADDI  = 6'b001000;
   localparam opc_t OP_SLTI  = 6'b001010;
   localparam opc_t OP_ANDI  = 6'b001100;
   localparam opc_t OP_ORI   = 6'b001101;
   localparam opc_t OP_LW    = 6'b100011;
   localparam opc_t OP_SW    = 6'b101011;

   typedef enum logic [1:0] {
      ALU_ADD   = 2'b00,
      ALU_SUB   = 2'b01,
      ALU_FUNCT = 2'b10,
      ALU_IMM   = 2'b11
   } alu_op_e;

   typedef enum logic [1:0] {
      SRCB_B       = 2'b00,
      SRCB_FOUR    = 2'b01,
      SRCB_IMM     = 2'b10,
      SRCB_IMM_SH2 = 2'b11
   } alu_src_b_e;

   typedef enum logic [1:0] {
      PCSRC_ALU    = 2'b00,
      PCSRC_ALUOUT = 2'b01,
      PCSRC_JUMP   = 2'b10,
      PCSRC_RSVD   = 2'b11
   } pc_source_e;

   typedef struct packed {
      logic       pc_write;
      logic       pc_write_cond;
      logic       iord;
      logic       mem_read;
      logic       mem_write;
      logic       ir_write;
      logic       mem_to_reg;
      logic       reg_dst;
      logic       reg_write;
      logic       alu_src_a;
      alu_src_b_e alu_src_b;
      alu_op_e    alu_op;
      pc_source_e pc_source;
   } ctrl_t;

   // Immediate ALU opcodes that are routed to IEX when that feature is built in.
   function automatic logic is_imm_op(opc_t op);
      return (op == OP_ADDI) || (op == OP_ANDI) || (op == OP_ORI) || (op == OP_SLTI);
   endfunction

endpackage

// File: rtl/mc_ctrl_fsm_if.sv
// Control-unit boundary: IR opcode and status in, datapath control pins out.
// master = control FSM, slave = datapath.
interface mc_ctrl_fsm_if #(
   parameter int OPC_W   = 6,
   parameter int STATE_W = 4
);
   logic [OPC_W-1:0]   opcode;
   logic               zero;
   logic               mem_ready;
   logic               pc_write;
   logic               pc_write_cond;
   logic               pc_en;
   logic               iord;
   logic               mem_read;
   logic               mem_write;
   logic               ir_write;
   logic               mem_to_reg;
   logic               reg_dst;
   logic               reg_write;
   logic               alu_src_a;
   logic [1:0]         alu_src_b;
   logic [1:0]         alu_op;
   logic [1:0]         pc_source;
   logic               illegal_op;
   logic [STATE_W-1:0] state_o;

   modport master (
      input  opcode, zero, mem_ready,
      output pc_write, pc_write_cond, pc_en, iord, mem_read, mem_write, ir_write,
             mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
             pc_source, illegal_op, state_o
   );

   modport slave (
      output opcode, zero, mem_ready,
      input  pc_write, pc_write_cond, pc_en, iord, mem_read, mem_write, ir_write,
             mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
             pc_source, illegal_op, state_o
   );
endinterface

// File: rtl/mc_ctrl_decode.sv
// Moore output decoder: maps the current state to the datapath control bundle.
// The IEX/IWB decodes exist only when MC_IMM_ALU_EN is defined.
module mc_ctrl_decode
   import mc_pkg::*;
(
   input  state_e state,
   input  logic   mem_ready,
   output ctrl_t  ctrl
);

   always_comb begin
      // NOTE: defaulting the whole bundle first keeps every path assigned, so no latch is inferred.
      ctrl = '0;
      case (state)
         S_IF: begin
            ctrl.mem_read  = 1'b1;
            ctrl.alu_src_b = SRCB_FOUR;
            ctrl.ir_write  = mem_ready;
            ctrl.pc_write  = mem_ready;
         end
         S_ID: begin
            ctrl.alu_src_b = SRCB_IMM_SH2;
         end
         S_MADDR: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRCB_IMM;
         end
         S_MRD: begin
            ctrl.mem_read = 1'b1;
            ctrl.iord     = 1'b1;
         end
         S_MWB: begin
            ctrl.reg_write  = 1'b1;
            ctrl.mem_to_reg = 1'b1;
         end
         S_MWR: begin
            ctrl.mem_write = 1'b1;
            ctrl.iord      = 1'b1;
         end
         S_REX: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_op    = ALU_FUNCT;
         end
         S_RWB: begin
            ctrl.reg_write = 1'b1;
            ctrl.reg_dst   = 1'b1;
         end
         S_BEQ: begin
            ctrl.alu_src_a     = 1'b1;
            ctrl.alu_op        = ALU_SUB;
            ctrl.pc_write_cond = 1'b1;
            ctrl.pc_source     = PCSRC_ALUOUT;
         end
         S_JMP: begin
            ctrl.pc_write  = 1'b1;
            ctrl.pc_source = PCSRC_JUMP;
         end
`ifdef MC_IMM_ALU_EN
         S_IEX: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRCB_IMM;
            ctrl.alu_op    = ALU_IMM;
         end
         S_IWB: begin
            ctrl.reg_write = 1'b1;
         end
`endif
         default: ;
      endcase
   end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle CPU main control FSM: state register, next-state logic, illegal_op pulse.
// Define MC_IMM_ALU_EN to decode addi/andi/ori/slti through IEX/IWB.
module mc_ctrl_fsm
   import mc_pkg::*;
#(
   parameter int STATE_W = 4,
   parameter int OPC_W   = 6
) (
   input logic          clk,
   input logic          rst,
   mc_ctrl_fsm_if.master bus
);

   state_e           state_q;
   logic             illegal_op_q;
   logic [OPC_W-1:0] opc_raw;
   opc_t             opcode;
   ctrl_t            ctrl;

   assign opc_raw = bus.opcode;
   assign opcode  = opc_t'(opc_raw);

   // NOTE: synchronous reset inside the clocked block, and <= for every register so all updates see pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IF;
         illegal_op_q <= 1'b0;
      end else begin
         illegal_op_q <= 1'b0;
         case (state_q)
            S_IF:  if (bus.mem_ready) state_q <= S_ID;
            S_ID: begin
               if (opcode == OP_LW || opcode == OP_SW) state_q <= S_MADDR;
               else if (opcode == OP_RTYPE)            state_q <= S_REX;
               else if (opcode == OP_BEQ)              state_q <= S_BEQ;
               else if (opcode == OP_J)                state_q <= S_JMP;
`ifdef MC_IMM_ALU_EN
               else if (is_imm_op(opcode))             state_q <= S_IEX;
`endif
               else begin
                  state_q      <= S_IF;
                  illegal_op_q <= 1'b1;
               end
            end
            // IR is stable, so the opcode can be re-read to split lw from sw.
            S_MADDR: state_q <= (opcode == OP_LW) ? S_MRD : S_MWR;
            S_MRD:   if (bus.mem_ready) state_q <= S_MWB;
            S_MWR:   if (bus.mem_ready) state_q <= S_IF;
            S_REX:   state_q <= S_RWB;
`ifdef MC_IMM_ALU_EN
            S_IEX:   state_q <= S_IWB;
`endif
            S_MWB, S_RWB, S_BEQ, S_JMP: state_q <= S_IF;
            default: state_q <= S_IF;
         endcase
      end
   end

   mc_ctrl_decode u_decode (
      .state     (state_q),
      .mem_ready (bus.mem_ready),
      .ctrl      (ctrl)
   );

   assign bus.pc_write      = ctrl.pc_write;
   assign bus.pc_write_cond = ctrl.pc_write_cond;
   assign bus.pc_en         = ctrl.pc_write | (ctrl.pc_write_cond & bus.zero);
   assign bus.iord          = ctrl.iord;
   assign bus.mem_read      = ctrl.mem_read;
   assign bus.mem_write     = ctrl.mem_write;
   assign bus.ir_write      = ctrl.ir_write;
   assign bus.mem_to_reg    = ctrl.mem_to_reg;
   assign bus.reg_dst       = ctrl.reg_dst;
   assign bus.reg_write     = ctrl.reg_write;
   assign bus.alu_src_a     = ctrl.alu_src_a;
   assign bus.alu_src_b     = ctrl.alu_src_b;
   assign bus.alu_op        = ctrl.alu_op;
   assign bus.pc_source     = ctrl.pc_source;
   assign bus.illegal_op    = illegal_op_q;
   assign bus.state_o       = STATE_W'(state_q);

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Directed self-checking bench for mc_ctrl_fsm; outputs sampled on the falling edge.
// Honours MC_IMM_ALU_EN for the immediate-op scenario.
module tb_mc_ctrl_fsm;

   logic clk;
   logic rst;
   int   errors = 0;
   int   checks = 0;

   mc_ctrl_fsm_if #(.OPC_W(6), .STATE_W(4)) bus ();

   mc_ctrl_fsm #(.STATE_W(4), .OPC_W(6)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.mem_ready = 1'b0;
      bus.opcode = 6'b000000;
      bus.zero = 1'b0;
      cyc();
      cyc();
      rst = 1'b0;
      @(negedge clk);
      checks++; if (bus.state_o !== 4'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", bus.state_o); end
      checks++; if (bus.illegal_op !== 1'b0) begin errors++; $display("FAIL reset_illegal: got %0b expected 0", bus.illegal_op); end
      checks++; if (bus.mem_read !== 1'b1) begin errors++; $display("FAIL reset_mem_read: got %0b expected 1", bus.mem_read); end
      checks++; if (bus.ir_write !== 1'b0) begin errors++; $display("FAIL reset_ir_write_stall: got %0b expected 0", bus.ir_write); end
      checks++; if (bus.pc_en !== 1'b0) begin errors++; $display("FAIL reset_pc_en_stall: got %0b expected 0", bus.pc_en); end
      cyc();
   endtask

   task automatic test_rtype();
      int exp_st[5] = '{0, 1, 6, 7, 0};
      bus.opcode = 6'b000000;
      bus.mem_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         if (i == 3) bus.mem_ready = 1'b0;
         @(negedge clk);
         checks++; if (bus.state_o !== 4'(exp_st[i])) begin errors++; $display("FAIL rtype_state[%0d]: got %0d expected %0d", i, bus.state_o, exp_st[i]); end
         checks++; if (bus.ir_write !== 1'(i == 0)) begin errors++; $display("FAIL rtype_ir_write[%0d]: got %0b expected %0b", i, bus.ir_write, i == 0); end
         checks++; if (bus.reg_write !== 1'(i == 3)) begin errors++; $display("FAIL rtype_reg_write[%0d]: got %0b expected %0b", i, bus.reg_write, i == 3); end
         checks++; if (bus.reg_dst !== 1'(i == 3)) begin errors++; $display("FAIL rtype_reg_dst[%0d]: got %0b expected %0b", i, bus.reg_dst, i == 3); end
         if (i == 1) begin
            checks++; if (bus.alu_src_b !== 2'b11) begin errors++; $display("FAIL id_alu_src_b: got %0d expected 3", bus.alu_src_b); end
         end
         if (i == 2) begin
            checks++; if (bus.alu_op !== 2'b10) begin errors++; $display("FAIL rex_alu_op: got %0d expected 2", bus.alu_op); end
            checks++; if (bus.alu_src_b !== 2'b00) begin errors++; $display("FAIL rex_alu_src_b: got %0d expected 0", bus.alu_src_b); end
            checks++; if (bus.alu_src_a !== 1'b1) begin errors++; $display("FAIL rex_alu_src_a: got %0b expected 1", bus.alu_src_a); end
         end
         if (i < 4) cyc();
      end
      cyc();
   endtask

   task automatic test_lw_stall();
      int exp_st[10] = '{0, 0, 0, 1, 2, 3, 3, 3, 3, 4};
      bit rdy[10]    = '{0, 0, 1, 1, 1, 0, 0, 0, 1, 0};
      bus.opcode = 6'b100011;
      for (int i = 0; i < 10; i++) begin
         bus.mem_ready = rdy[i];
         @(negedge clk);
         checks++; if (bus.state_o !== 4'(exp_st[i])) begin errors++; $display("FAIL lw_state[%0d]: got %0d expected %0d", i, bus.state_o, exp_st[i]); end
         checks++; if (bus.ir_write !== 1'(exp_st[i] == 0 && rdy[i])) begin errors++; $display("FAIL lw_ir_write[%0d]: got %0b", i, bus.ir_write); end
         if (exp_st[i] == 3) begin
            checks++; if (bus.mem_read !== 1'b1) begin errors++; $display("FAIL lw_mrd_mem_read[%0d]: got %0b expected 1", i, bus.mem_read); end
            checks++; if (bus.iord !== 1'b1) begin errors++; $display("FAIL lw_mrd_iord[%0d]: got %0b expected 1", i, bus.iord); end
         end
         if (exp_st[i] == 4) begin
            checks++; if (bus.mem_to_reg !== 1'b1) begin errors++; $display("FAIL lw_mwb_mem_to_reg: got %0b expected 1", bus.mem_to_reg); end
            checks++; if (bus.reg_write !== 1'b1) begin errors++; $display("FAIL lw_mwb_reg_write: got %0b expected 1", bus.reg_write); end
            checks++; if (bus.reg_dst !== 1'b0) begin errors++; $display("FAIL lw_mwb_reg_dst: got %0b expected 0", bus.reg_dst); end
         end
         cyc();
      end
      bus.mem_ready = 1'b0;
      @(negedge clk);
      checks++; if (bus.state_o !== 4'd0) begin errors++; $display("FAIL lw_return_if: got %0d expected 0", bus.state_o); end
      cyc();
   endtask

   task automatic test_beq();
      for (int zi = 0; zi < 2; zi++) begin
         logic z;
         z = (zi == 0);
         bus.opcode = 6'b000100;
         bus.zero = z;
         bus.mem_ready = 1'b1;
         @(negedge clk);
         checks++; if (bus.pc_en !== 1'b1) begin errors++; $display("FAIL beq_if_pc_en: got %0b expected 1", bus.pc_en); end
         cyc();
         bus.mem_ready = 1'b0;
         @(negedge clk);
         checks++; if (bus.pc_en !== 1'b0) begin errors++; $display("FAIL beq_id_pc_en z=%0b: got %0b expected 0", z, bus.pc_en); end
         cyc();
         @(negedge clk);
         checks++; if (bus.state_o !== 4'd8) begin errors++; $display("FAIL beq_state z=%0b: got %0d expected 8", z, bus.state_o); end
         checks++; if (bus.pc_en !== z) begin errors++; $display("FAIL beq_pc_en z=%0b: got %0b expected %0b", z, bus.pc_en, z); end
         checks++; if (bus.pc_source !== 2'b01) begin errors++; $display("FAIL beq_pc_source: got %0d expected 1", bus.pc_source); end
         checks++; if (bus.alu_op !== 2'b01) begin errors++; $display("FAIL beq_alu_op: got %0d expected 1", bus.alu_op); end
         cyc();
         @(negedge clk);
         checks++; if (bus.state_o !== 4'd0) begin errors++; $display("FAIL beq_return_if: got %0d expected 0", bus.state_o); end
         cyc();
      end
      bus.zero = 1'b0;
   endtask

   task automatic test_jmp();
      bus.opcode = 6'b000010;
      bus.mem_ready = 1'b1;
      cyc();
      bus.mem_ready = 1'b0;
      cyc();
      @(negedge clk);
      checks++; if (bus.state_o !== 4'd9) begin errors++; $display("FAIL jmp_state: got %0d expected 9", bus.state_o); end
      checks++; if (bus.pc_source !== 2'b10) begin errors++; $display("FAIL jmp_pc_source: got %0d expected 2", bus.pc_source); end
      checks++; if (bus.pc_en !== 1'b1) begin errors++; $display("FAIL jmp_pc_en: got %0b expected 1", bus.pc_en); end
      cyc();
      @(negedge clk);
      checks++; if (bus.state_o !== 4'd0) begin errors++; $display("FAIL jmp_return_if: got %0d expected 0", bus.state_o); end
      cyc();
   endtask

   task automatic test_illegal(input logic [5:0] opc, input string tag);
      int exp_st[4] = '{0, 1, 0, 0};
      bus.opcode = opc;
      bus.mem_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checks++; if (bus.state_o !== 4'(exp_st[i])) begin errors++; $display("FAIL %s_state[%0d]: got %0d expected %0d", tag, i, bus.state_o, exp_st[i]); end
         checks++; if (bus.illegal_op !== 1'(i == 2)) begin errors++; $display("FAIL %s_illegal_op[%0d]: got %0b expected %0b", tag, i, bus.illegal_op, i == 2); end
         checks++; if (bus.reg_write !== 1'b0 || bus.mem_write !== 1'b0) begin errors++; $display("FAIL %s_no_write[%0d]: got reg_write=%0b mem_write=%0b expected 0", tag, i, bus.reg_write, bus.mem_write); end
         cyc();
         bus.mem_ready = 1'b0;
      end
   endtask

   task automatic test_imm();
`ifdef MC_IMM_ALU_EN
      int exp_st[5] = '{0, 1, 10, 11, 0};
      bus.opcode = 6'b001101;
      bus.mem_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checks++; if (bus.state_o !== 4'(exp_st[i])) begin errors++; $display("FAIL imm_state[%0d]: got %0d expected %0d", i, bus.state_o, exp_st[i]); end
         checks++; if (bus.alu_op !== ((i == 2) ? 2'b11 : 2'b00)) begin errors++; $display("FAIL imm_alu_op[%0d]: got %0d", i, bus.alu_op); end
         checks++; if (bus.reg_write !== 1'(i == 3)) begin errors++; $display("FAIL imm_reg_write[%0d]: got %0b", i, bus.reg_write); end
         cyc();
         bus.mem_ready = 1'b0;
      end
`else
      test_illegal(6'b001101, "imm_disabled");
`endif
   endtask

   task automatic test_sw_reset();
      bus.opcode = 6'b101011;
      bus.mem_ready = 1'b1;
      cyc();
      bus.mem_ready = 1'b0;
      cyc();
      @(negedge clk);
      checks++; if (bus.state_o !== 4'd2) begin errors++; $display("FAIL sw_maddr_state: got %0d expected 2", bus.state_o); end
      cyc();
      cyc();
      @(negedge clk);
      checks++; if (bus.state_o !== 4'd5) begin errors++; $display("FAIL sw_stall_state: got %0d expected 5", bus.state_o); end
      checks++; if (bus.mem_write !== 1'b1 || bus.iord !== 1'b1) begin errors++; $display("FAIL sw_stall_strobe: got mem_write=%0b iord=%0b expected 1", bus.mem_write, bus.iord); end
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++; if (bus.state_o !== 4'd0) begin errors++; $display("FAIL sw_reset_state[%0d]: got %0d expected 0", i, bus.state_o); end
         checks++; if (bus.mem_write !== 1'b0) begin errors++; $display("FAIL sw_reset_mem_write[%0d]: got %0b expected 0", i, bus.mem_write); end
         cyc();
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_rtype();
      test_lw_stall();
      test_beq();
      test_jmp();
      test_illegal(6'b111111, "illegal");
      test_imm();
      test_sw_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
